reg_scoreboard: RTL

- Decode-stage register read control with a per-register pending-write scoreboard.
- Decodes rs1/rs2 read enables and the rd write enable from the RV32 instruction word.
- Counts in-flight writes per architectural register and produces a RAW/overflow stall.
- Sits between the fetch/decode register and the ID/EX pipeline register; writeback clears its entries.

---
 rtl/reg_scoreboard.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// Decode-stage register read control with a per-register pending-write scoreboard.
// Optional macro REG_SCOREBOARD_WB_BYPASS_EN lets a same-cycle final writeback release a dependent read.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_PEND = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                instr_valid,
    input  logic                ex_ready,
    input  logic                flush,
    input  logic                wb_valid,
    input  logic [REG_AW-1:0]   wb_rd,
    output logic [REG_AW-1:0]   rs1_addr,
    output logic [REG_AW-1:0]   rs2_addr,
    output logic                rs1_rden,
    output logic                rs2_rden,
    output logic [REG_AW-1:0]   rd_addr,
    output logic                rd_wren,
    output logic                stall,
    output logic                issue,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                err_underflow
);
    localparam int CNT_W = $clog2(MAX_PEND + 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_MEM    = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    instr_t              f;
    logic                writes_rd;
    logic                hazard;
    logic                rd_full;
    logic [NUM_REGS-1:0] busy_eff;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic                underflow;
    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic                unused_bits;

    assign f           = instr_t'(instr);
    assign unused_bits = ^{f.funct7, f.funct3};

    always_comb begin
        rs1_rden  = 1'b0;
        rs2_rden  = 1'b0;
        writes_rd = 1'b0;
        case (f.opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM: writes_rd = 1'b1;
            OP_JALR, OP_LOAD, OP_IMM: begin
                rs1_rden  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                rs1_rden = 1'b1;
                rs2_rden = 1'b1;
            end
            OP_REG: begin
                rs1_rden  = 1'b1;
                rs2_rden  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_MEM:  rs1_rden = 1'b1;
            default: ;
        endcase
    end

    assign rd_wren  = writes_rd && (f.rd != 5'd0);
    assign rs1_addr = rs1_rden ? REG_AW'(f.rs1) : '0;
    assign rs2_addr = rs2_rden ? REG_AW'(f.rs2) : '0;
    assign rd_addr  = rd_wren  ? REG_AW'(f.rd)  : '0;

    // Register 0 never holds a count, so reads of x0 are never busy.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_vec[r] = (cnt[r] != '0);
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
            busy_eff[r] = busy_vec[r] &&
                          !(wb_valid && (wb_rd == REG_AW'(r)) && (cnt[r] == ONE_C));
`else
            busy_eff[r] = busy_vec[r];
`endif
        end
    end

`ifdef REG_SCOREBOARD_WB_BYPASS_EN
    assign rd_full = (cnt[rd_addr] == MAX_C) && !(wb_valid && (wb_rd == rd_addr));
`else
    assign rd_full = (cnt[rd_addr] == MAX_C);
`endif

    assign hazard = instr_valid && ((rs1_rden && busy_eff[rs1_addr]) ||
                                    (rs2_rden && busy_eff[rs2_addr]) ||
                                    (rd_wren  && rd_full));
    assign stall  = hazard;
    assign issue  = instr_valid && !hazard && ex_ready && !flush;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_vec[r] = issue && rd_wren && (rd_addr == REG_AW'(r));
            dec_vec[r] = wb_valid && (wb_rd == REG_AW'(r)) && (cnt[r] != '0);
        end
    end

    assign underflow = wb_valid && (wb_rd != '0) && (cnt[wb_rd] == '0);

    // Flush wipes all pending state and drops any same-cycle issue or writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
            err_underflow <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    cnt[r] <= cnt[r] + ONE_C;
                else if (dec_vec[r] && !inc_vec[r])
                    cnt[r] <= cnt[r] - ONE_C;
            end
            if (underflow) err_underflow <= 1'b1;
        end
    end
endmodule
